pipe_in_pattern_checker: RTL and testbench

Parametrised PipeIn integrity checker for host-to-FPGA benchmark bitfiles. It sits behind an okBTPipeIn endpoint on okClk. It regenerates the expected data stream for a selectable pattern across WIDTH/32 lanes and compares it word-for-word against received data. It throttles pipe_in_ready from a programmable rotate mask and reports error count, word count, first-error location and ready violations for WireOuts.

---
 rtl/pipe_in_pattern_checker.sv | 135 +++++++++++++
 tb/tb_pipe_in_pattern_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_in_pattern_checker.sv
// PipeIn integrity checker: regenerates the expected pattern per 32-bit lane,
// compares each written word and reports error/word counts, first error and ready violations.
module pipe_in_pattern_checker #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned CNT_W        = 32,
   parameter logic [31:0] LFSR_SEED    = 32'h0D0C_0B0A,
   parameter logic [31:0] THROTTLE_RST = 32'hFFFF_FFFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic [2:0]       pattern,
   input  logic [31:0]      fixed_pattern,
   input  logic             throttle_set,
   input  logic [31:0]      throttle_val,
   input  logic             pipe_in_write,
   input  logic [WIDTH-1:0] pipe_in_data,
   output logic             pipe_in_ready,
   output logic [CNT_W-1:0] error_count,
   output logic [31:0]      word_count,
   output logic             first_err_valid,
   output logic [31:0]      first_err_index,
   output logic             ready_violation
);

   localparam int unsigned LANES = WIDTH / 32;

   typedef enum logic [1:0] {
      PAT_COUNT,
      PAT_FIXED,
      PAT_LFSR,
      PAT_WALK
   } pat_e;

   pat_e                        active_pattern;
   pat_e                        pattern_dec;
   logic [31:0]                 throttle_reg;
   logic [LANES-1:0][31:0]      lfsr_q;
   logic [WIDTH-1:0]            expected;
   logic                        cmp_valid;
   logic                        cmp_err;
   logic [31:0]                 cmp_idx;

   function automatic logic [LANES-1:0][31:0] lfsr_seeds();
      logic [LANES-1:0][31:0] s;
      for (int unsigned l = 0; l < LANES; l++) s[l] = LFSR_SEED ^ 32'(l);
      return s;
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] r);
      return {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
   endfunction

   always_comb begin
      case (pattern)
         3'd1:    pattern_dec = PAT_FIXED;
         3'd2:    pattern_dec = PAT_LFSR;
         3'd3:    pattern_dec = PAT_WALK;
         default: pattern_dec = PAT_COUNT;
      endcase
   end

   // Expected word for index word_count, built lane by lane
   always_comb begin
      expected = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         case (active_pattern)
            PAT_FIXED: expected[32*l +: 32] = fixed_pattern;
            PAT_LFSR:  expected[32*l +: 32] = lfsr_q[l];
            PAT_WALK:  expected[32*l +: 32] = 32'h1 << 5'(word_count[4:0] + 5'(l));
            default:   expected[32*l +: 32] = word_count * 32'(LANES) + 32'(l);
         endcase
      end
   end

   // throttle_set outranks restart for the throttle register only
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         throttle_reg  <= THROTTLE_RST;
         pipe_in_ready <= THROTTLE_RST[31];
      end else begin
         if (throttle_set)
            throttle_reg <= throttle_val;
         else if (restart)
            throttle_reg <= THROTTLE_RST;
         else
            throttle_reg <= {throttle_reg[30:0], throttle_reg[31]};
         pipe_in_ready <= restart ? THROTTLE_RST[31] : throttle_reg[31];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_pattern  <= PAT_COUNT;
         lfsr_q          <= lfsr_seeds();
         word_count      <= '0;
         cmp_valid       <= 1'b0;
         cmp_err         <= 1'b0;
         cmp_idx         <= '0;
         error_count     <= '0;
         first_err_valid <= 1'b0;
         first_err_index <= '0;
         ready_violation <= 1'b0;
      end else if (restart) begin
         active_pattern  <= pattern_dec;
         lfsr_q          <= lfsr_seeds();
         word_count      <= '0;
         cmp_valid       <= 1'b0;
         cmp_err         <= 1'b0;
         cmp_idx         <= '0;
         error_count     <= '0;
         first_err_valid <= 1'b0;
         first_err_index <= '0;
         ready_violation <= 1'b0;
      end else begin
         cmp_valid <= pipe_in_write;
         if (pipe_in_write) begin
            cmp_err    <= (pipe_in_data != expected);
            cmp_idx    <= word_count;
            word_count <= word_count + 32'd1;
            for (int unsigned l = 0; l < LANES; l++) lfsr_q[l] <= lfsr_step(lfsr_q[l]);
            if (!pipe_in_ready) ready_violation <= 1'b1;
         end
         // Compare result of the previous write lands one cycle late
         if (cmp_valid && cmp_err) begin
            if (error_count != '1) error_count <= error_count + CNT_W'(1);
            if (!first_err_valid) begin
               first_err_valid <= 1'b1;
               first_err_index <= cmp_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_in_pattern_checker.sv
// Randomized scoreboard bench for pipe_in_pattern_checker (WIDTH=64, CNT_W=8).
module tb_pipe_in_pattern_checker;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned LANES = WIDTH / 32;
   localparam logic [31:0] SEED  = 32'h0D0C_0B0A;
   localparam logic [31:0] TRST  = 32'hFFFF_FFFF;
   localparam int unsigned ESAT  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             restart = 1'b0;
   logic [2:0]       pattern = '0;
   logic [31:0]      fixed_pattern = '0;
   logic             throttle_set = 1'b0;
   logic [31:0]      throttle_val = '0;
   logic             pipe_in_write = 1'b0;
   logic [WIDTH-1:0] pipe_in_data = '0;
   logic             pipe_in_ready;
   logic [CNT_W-1:0] error_count;
   logic [31:0]      word_count;
   logic             first_err_valid;
   logic [31:0]      first_err_index;
   logic             ready_violation;

   pipe_in_pattern_checker #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W),
      .LFSR_SEED(SEED),
      .THROTTLE_RST(TRST)
   ) dut (
      .clk(clk),
      .reset(reset),
      .restart(restart),
      .pattern(pattern),
      .fixed_pattern(fixed_pattern),
      .throttle_set(throttle_set),
      .throttle_val(throttle_val),
      .pipe_in_write(pipe_in_write),
      .pipe_in_data(pipe_in_data),
      .pipe_in_ready(pipe_in_ready),
      .error_count(error_count),
      .word_count(word_count),
      .first_err_valid(first_err_valid),
      .first_err_index(first_err_index),
      .ready_violation(ready_violation)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned ec;
      logic [31:0] wc;
      logic        fev;
      logic [31:0] fei;
      logic        rv;
      logic        rdy;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference model state
   logic [31:0] m_n, m_fei, m_thr, m_pi;
   int unsigned m_err, m_pat;
   logic        m_fev, m_rv, m_rdy, m_pv, m_pe;

   function automatic logic [31:0] lfsr_at(input int unsigned l, input logic [31:0] n);
      logic [31:0] r;
      r = SEED ^ l;
      for (int unsigned k = 0; k < n; k++) r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] model_word();
      logic [WIDTH-1:0] w;
      for (int unsigned l = 0; l < LANES; l++) begin
         case (m_pat)
            1:       w[32*l +: 32] = fixed_pattern;
            2:       w[32*l +: 32] = lfsr_at(l, m_n);
            3:       w[32*l +: 32] = 32'h1 << ((m_n + l) % 32);
            default: w[32*l +: 32] = m_n * LANES + l;
         endcase
      end
      return w;
   endfunction

   task automatic model_reset(input int unsigned pat);
      m_n = 0; m_err = 0; m_fev = 0; m_fei = 0; m_rv = 0; m_pv = 0; m_pe = 0; m_pi = 0;
      m_rdy = TRST[31];
      m_pat = (pat > 3) ? 0 : pat;
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.ec = m_err; e.wc = m_n; e.fev = m_fev; e.fei = m_fei; e.rv = m_rv; e.rdy = m_rdy;
      return e;
   endfunction

   task automatic model_edge();
      logic old_rdy;
      if (reset) begin
         model_reset(0);
         m_thr = TRST;
      end else begin
         if (m_pv && m_pe) begin
            if (m_err < ESAT) m_err++;
            if (!m_fev) begin m_fev = 1; m_fei = m_pi; end
         end
         old_rdy = m_rdy;
         if (restart) begin
            model_reset(int'(pattern));
            m_thr = throttle_set ? throttle_val : TRST;
         end else begin
            m_rdy = m_thr[31];
            m_thr = throttle_set ? throttle_val : {m_thr[30:0], m_thr[31]};
            m_pv  = pipe_in_write;
            if (pipe_in_write) begin
               m_pe = (pipe_in_data != model_word());
               m_pi = m_n;
               m_n  = m_n + 1;
               if (!old_rdy) m_rv = 1;
            end
         end
      end
      exp_q.push_back(snapshot());
   endtask

   task automatic cyc(input logic w, input logic [WIDTH-1:0] d);
      pipe_in_write = w;
      pipe_in_data  = d;
      @(posedge clk);
      model_edge();
      #1;
      restart       = 1'b0;
      pipe_in_write = 1'b0;
   endtask

   task automatic do_restart(input logic [2:0] p);
      pattern = p;
      restart = 1'b1;
      cyc(1'b1, '1);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: compares DUT outputs against the next expected entry each cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("error_count", 32'(error_count), e.ec);
            chk("word_count", word_count, e.wc);
            chk("first_err_valid", 32'(first_err_valid), 32'(e.fev));
            chk("first_err_index", first_err_index, e.fei);
            chk("ready_violation", 32'(ready_violation), 32'(e.rv));
            chk("pipe_in_ready", 32'(pipe_in_ready), 32'(e.rdy));
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] d;
      exp_t             e;
      model_reset(0);
      m_thr = TRST;
      cyc(1'b0, '0);
      cyc(1'b0, '0);
      reset = 1'b0;
      cyc(1'b0, '0);

      // Count pattern, four clean words
      do_restart(3'd0);
      for (int i = 0; i < 4; i++) cyc(1'b1, model_word());
      cyc(1'b0, '0); cyc(1'b0, '0);

      // LFSR with one corrupted word at index 3
      do_restart(3'd2);
      for (int i = 0; i < 6; i++) begin
         d = model_word();
         if (i == 3) d = d ^ 64'h1;
         cyc(1'b1, d);
      end
      cyc(1'b0, '0); cyc(1'b0, '0);

      // Fixed pattern sampled live
      fixed_pattern = 32'hA5A5_5A5A;
      do_restart(3'd1);
      for (int i = 0; i < 10; i++) cyc(1'b1, {2{32'hA5A5_5A5A}});
      fixed_pattern = 32'h0;
      cyc(1'b1, {2{32'hA5A5_5A5A}});
      cyc(1'b0, '0); cyc(1'b0, '0);

      // Alternating throttle mask, writes regardless of ready
      throttle_set = 1'b1; throttle_val = 32'hAAAA_AAAA;
      cyc(1'b0, '0);
      throttle_set = 1'b0;
      for (int i = 0; i < 12; i++) cyc(1'($urandom % 2), model_word());
      cyc(1'b0, '0);

      // Randomized rounds across all pattern codes
      for (int r = 0; r < 5; r++) begin
         do_restart(3'($urandom % 8));
         for (int i = 0; i < 40; i++) begin
            fixed_pattern = ($urandom % 4 == 0) ? $urandom : fixed_pattern;
            throttle_set  = ($urandom % 8 == 0);
            throttle_val  = $urandom;
            d = model_word();
            if ($urandom % 4 == 0) d = d ^ (64'h1 << ($urandom % 64));
            cyc(1'($urandom % 3 != 0), d);
         end
         throttle_set = 1'b0;
         cyc(1'b0, '0);
      end

      // Saturation of error_count
      do_restart(3'd0);
      for (int i = 0; i < 300; i++) cyc(1'b1, '0);
      cyc(1'b0, '0); cyc(1'b0, '0);

      // Async reset just after a bad write; its compare result must be dropped
      do_restart(3'd3);
      cyc(1'b1, model_word());
      cyc(1'b1, model_word());
      cyc(1'b1, ~model_word());
      #1;
      reset = 1'b1;
      e = exp_q.pop_back();
      model_reset(0);
      m_thr = TRST;
      exp_q.push_back(snapshot());
      #5;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1'b0, '0);

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
